// File: rtl/des_key_sched_iter.sv
// Iterative DES key schedule: latches PC1(key) on a key handshake and presents one
// PC2 subkey per output handshake, forward (K1..K16) or reverse (K16..K1).
//   state | meaning
//   IDLE  | waiting for a key, key_ready high once out of reset
//   RUN   | presenting subkey for round_q, C/D advance per handshake
//   DRAIN | one dead cycle after round 16 before the next key
module des_key_sched_iter #(
    parameter int PARITY_CHK = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [64:1] key,
    input  logic        decrypt,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [48:1] subkey,
    output logic [4:0]  round,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        subkey_last,
    output logic        parity_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [27:0] cur_c, cur_d;
    logic [4:0]  round_q, round_d;
    logic        dec_q, dec_d;
    logic        perr_q, perr_d;
    logic        armed_q;

    // cd[55] holds DES bit 1 of the C||D concatenation
    function automatic logic [55:0] pc1(input logic [64:1] k);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) cd[55-i] = k[65-PC1_TAB[i]];
        return cd;
    endfunction

    function automatic logic [48:1] pc2(input logic [27:0] c, input logic [27:0] d);
        logic [55:0] cd;
        logic [48:1] ks;
        cd = {c, d};
        ks = '0;
        for (int j = 0; j < 48; j++) ks[48-j] = cd[56-PC2_TAB[j]];
        return ks;
    endfunction

    function automatic logic two_bit_shift(input logic [4:0] r);
        return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic key_parity_bad(input logic [64:1] k);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 8; i++) b |= ~^k[8*i+1 +: 8];
        return b;
    endfunction

    // c_q/d_q hold the previous round's halves; the presented round is derived from them
    always_comb begin
        cur_c = c_q;
        cur_d = d_q;
        if (!dec_q) begin
            cur_c = rotl(c_q, two_bit_shift(round_q));
            cur_d = rotl(d_q, two_bit_shift(round_q));
        end else if (round_q != 5'd1) begin
            cur_c = rotr(c_q, two_bit_shift(5'd18 - round_q));
            cur_d = rotr(d_q, two_bit_shift(5'd18 - round_q));
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        dec_d   = dec_q;
        perr_d  = perr_q;
        case (state_q)
            IDLE: begin
                if (key_valid && key_ready) begin
                    {c_d, d_d} = pc1(key);
                    dec_d      = decrypt;
                    round_d    = 5'd1;
                    perr_d     = (PARITY_CHK != 0) ? key_parity_bad(key) : 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (subkey_ready) begin
                    c_d = cur_c;
                    d_d = cur_d;
                    if (round_q == 5'd16) begin
                        round_d = 5'd0;
                        state_d = DRAIN;
                    end else begin
                        round_d = 5'(round_q + 5'd1);
                    end
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            perr_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            dec_q   <= dec_d;
            perr_q  <= perr_d;
            armed_q <= 1'b1;
        end
    end

    assign key_ready    = (state_q == IDLE) && armed_q;
    assign subkey_valid = (state_q == RUN);
    assign round        = round_q;
    assign subkey       = subkey_valid ? pc2(cur_c, cur_d) : '0;
    assign subkey_last  = subkey_valid && (round_q == 5'd16);
    assign parity_err   = perr_q;

endmodule

// File: tb/tb_des_key_sched_iter.sv
// Scoreboard bench for des_key_sched_iter: a DES-table reference model queues the
// expected subkey stream per key; monitors pop and compare on each output handshake.
module tb_des_key_sched_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [64:1] key;
    logic        decrypt, key_valid, subkey_ready;
    logic        key_ready, subkey_valid, subkey_last, parity_err;
    logic [48:1] subkey;
    logic [4:0]  round;
    logic        key_ready_p, subkey_valid_p, subkey_last_p, parity_err_p;
    logic [48:1] subkey_p;
    logic [4:0]  round_p;

    always #5 clk = ~clk;

    des_key_sched_iter #(.PARITY_CHK(0)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .decrypt(decrypt), .key_valid(key_valid),
        .key_ready(key_ready), .subkey(subkey), .round(round), .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready), .subkey_last(subkey_last), .parity_err(parity_err));

    des_key_sched_iter #(.PARITY_CHK(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .key(key), .decrypt(decrypt), .key_valid(key_valid),
        .key_ready(key_ready_p), .subkey(subkey_p), .round(round_p), .subkey_valid(subkey_valid_p),
        .subkey_ready(subkey_ready), .subkey_last(subkey_last_p), .parity_err(parity_err_p));

    typedef struct packed {
        logic [4:0]  rnd;
        logic [47:0] sk;
        logic        last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int total = 0;
    int bad   = 0;

    int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int sh_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    logic [47:0] mk [1:16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Subkey r from cumulative rotation of C0/D0 by the sum of the first r shifts.
    function automatic void model_keys(input logic [63:0] k);
        logic kb [1:64];
        logic c0 [28];
        logic d0 [28];
        logic cd [1:56];
        int   tot;
        for (int n = 1; n <= 64; n++) kb[n] = k[64-n];
        for (int i = 0; i < 28; i++) begin
            c0[i] = kb[pc1_t[i]];
            d0[i] = kb[pc1_t[28+i]];
        end
        tot = 0;
        for (int r = 1; r <= 16; r++) begin
            tot += sh_t[r-1];
            for (int i = 0; i < 28; i++) begin
                cd[1+i]  = c0[(i + tot) % 28];
                cd[29+i] = d0[(i + tot) % 28];
            end
            for (int j = 1; j <= 48; j++) mk[r][48-j] = cd[pc2_t[j-1]];
        end
    endfunction

    function automatic logic perr_of(input logic [63:0] k);
        for (int b = 0; b < 8; b++)
            if (($countones(k[8*b +: 8]) % 2) == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void push_sched(input logic [63:0] k, input logic dec);
        exp_t e;
        model_keys(k);
        for (int r = 1; r <= 16; r++) begin
            e.rnd  = 5'(r);
            e.sk   = dec ? mk[17-r] : mk[r];
            e.last = (r == 16);
            q0.push_back(e);
            q1.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("perr_off", {63'd0, parity_err}, 64'd0);
            if (subkey_valid && subkey_ready) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb0_unexpected: got round %0d with empty queue", round);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("sb0_round", {59'd0, round}, {59'd0, e.rnd});
                    chk("sb0_subkey", {16'd0, subkey}, {16'd0, e.sk});
                    chk("sb0_last", {63'd0, subkey_last}, {63'd0, e.last});
                end
            end else if (!subkey_valid) begin
                chk("sb0_idle_outs", {10'd0, round, subkey, subkey_last}, 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && subkey_valid_p && subkey_ready) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL sb1_unexpected: got round %0d with empty queue", round_p);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("sb1_round", {59'd0, round_p}, {59'd0, e.rnd});
                chk("sb1_subkey", {16'd0, subkey_p}, {16'd0, e.sk});
                chk("sb1_last", {63'd0, subkey_last_p}, {63'd0, e.last});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_key(input logic [63:0] k, input logic dec, input bit rand_rdy);
        int n = 0;
        while (!key_ready && n < 300) begin
            if (rand_rdy) subkey_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        if (!key_ready) begin
            total++; bad++;
            $display("FAIL key_ready_timeout: got 0 expected 1");
            return;
        end
        key = k; decrypt = dec; key_valid = 1'b1;
        push_sched(k, dec);
        tick();
        key_valid = 1'b0;
        key = {$urandom, $urandom};
        decrypt = 1'($urandom);
        chk("first_valid_round1", {58'd0, subkey_valid, round}, {58'd0, 1'b1, 5'd1});
        chk("parity_err_p", {63'd0, parity_err_p}, {63'd0, perr_of(k)});
    endtask

    task automatic wait_round(input logic [4:0] r);
        int n = 0;
        while (!(subkey_valid && round == r) && n < 200) begin
            tick();
            n++;
        end
        if (!(subkey_valid && round == r)) begin
            total++; bad++;
            $display("FAIL wait_round_timeout: got round %0d expected %0d", round, r);
        end
    endtask

    task automatic finish_sched();
        subkey_ready = 1'b1;
        wait_round(5'd16);
        tick();
        chk("drain_outs", {62'd0, subkey_valid, key_ready}, 64'd0);
        tick();
        chk("key_ready_after_drain", {63'd0, key_ready}, 64'd1);
    endtask

    initial begin
        logic [47:0] cap_sk;
        logic [4:0]  cap_rnd;
        rst_n = 1'b0; key = '0; decrypt = 1'b0; key_valid = 1'b0; subkey_ready = 1'b1;
        #23;
        chk("reset_outs", {6'd0, key_ready, subkey_valid, subkey_last, parity_err, round, subkey},
            64'd0);
        chk("reset_ready_p", {63'd0, key_ready_p}, 64'd0);
        tick();
        rst_n = 1'b1;
        chk("ready_before_edge", {63'd0, key_ready}, 64'd0);
        tick();
        chk("ready_after_reset", {63'd0, key_ready}, 64'd1);

        issue_key(64'h133457799BBCDFF1, 1'b0, 1'b0);
        chk("enc_k1", {16'd0, subkey}, {16'd0, 48'h1B02EFFC7072});
        repeat (15) tick();
        chk("enc_k16", {15'd0, subkey_last, subkey}, {15'd0, 1'b1, 48'hCB3D8B0E17F5});
        finish_sched();

        issue_key(64'h133457799BBCDFF1, 1'b1, 1'b0);
        chk("dec_r1", {16'd0, subkey}, {16'd0, 48'hCB3D8B0E17F5});
        repeat (15) tick();
        chk("dec_r16", {15'd0, subkey_last, subkey}, {15'd0, 1'b1, 48'h1B02EFFC7072});
        finish_sched();

        issue_key({$urandom, $urandom}, 1'b0, 1'b0);
        wait_round(5'd3);
        subkey_ready = 1'b0;
        cap_sk = subkey; cap_rnd = round;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", {10'd0, subkey_valid, round, subkey}, {10'd0, 1'b1, cap_rnd, cap_sk});
        end
        finish_sched();

        issue_key({$urandom, $urandom}, 1'b1, 1'b0);
        wait_round(5'd7);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outs", {6'd0, key_ready, subkey_valid, subkey_last, parity_err, round, subkey},
            64'd0);
        chk("midrun_reset_p", {13'd0, key_ready_p, subkey_valid_p, subkey_last_p, round_p, subkey_p},
            64'd0);
        q0.delete(); q1.delete();
        tick();
        rst_n = 1'b1;
        chk("ready_held_low", {63'd0, key_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_valid_after_reset", {62'd0, subkey_valid, key_ready}, 64'd1);
        end
        issue_key(64'h133457799BBCDFF1, 1'b0, 1'b0);
        chk("post_reset_k1", {16'd0, subkey}, {16'd0, 48'h1B02EFFC7072});
        finish_sched();

        issue_key(64'h133457799BBCDFF0, 1'b0, 1'b0);
        finish_sched();
        chk("parity_err_held", {63'd0, parity_err_p}, 64'd1);
        issue_key(64'h133457799BBCDFF1, 1'b1, 1'b0);
        finish_sched();

        issue_key({$urandom, $urandom}, 1'b0, 1'b0);
        wait_round(5'd9);
        key = {$urandom, $urandom}; decrypt = 1'($urandom); key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        finish_sched();

        for (int t = 0; t < 12; t++)
            issue_key({$urandom, $urandom}, 1'($urandom), 1'b1);
        subkey_ready = 1'b1;
        for (int n = 0; n < 60 && !key_ready; n++) tick();
        tick();
        chk("sb0_drained", 64'(q0.size()), 64'd0);
        chk("sb1_drained", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
